// File: rtl/ntt_addr_seq.sv
// Self-sequencing NTT butterfly address generator (Kyber radix-4 / Dilithium radix-2).
// Define ADDR_SEQ_INTT_EN to add the inv port (reverse stage order for the inverse NTT).
module ntt_addr_seq #(
    parameter int KY_LOGN   = 7,
    parameter int DI_LOGN   = 8,
    parameter int ADDR_W    = 8,
    parameter int STAGE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              KD_mode,
`ifdef ADDR_SEQ_INTT_EN
    input  logic              inv,
`endif
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] old_add_0,
    output logic [ADDR_W-1:0] old_add_1,
    output logic [ADDR_W-1:0] old_add_2,
    output logic [ADDR_W-1:0] old_add_3,
    output logic [2:0]        stage,
    output logic              stage_last,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (KY_LOGN - 2 > DI_LOGN - 1) ? KY_LOGN - 2 : DI_LOGN - 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    state_t              state_q, state_d;
    logic                kyb_q, kyb_d;
    logic                inv_q, inv_d;
    logic [2:0]          stage_q, stage_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]          nxt_stage;

    function automatic logic [IDX_W-1:0] f_last_idx(input logic kyb);
        return kyb ? IDX_W'((1 << (KY_LOGN - 2)) - 1)
                   : IDX_W'((1 << (DI_LOGN - 1)) - 1);
    endfunction

    function automatic logic [2:0] f_top(input logic kyb);
        return kyb ? 3'd3 : 3'(DI_LOGN - 1);
    endfunction

    // Divide/modulo by the power-of-two distance are pure shifts and masks.
    function automatic logic [4*ADDR_W-1:0] f_addr(input logic kyb,
                                                   input logic [2:0] stg,
                                                   input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] ix, d, base;
        int sh;
        ix = ADDR_W'(idx);
        if (kyb) sh = (stg == 3'd3) ? KY_LOGN - 2 : 2 * int'(stg);
        else     sh = int'(stg);
        d    = ADDR_W'(1) << sh;
        base = ((ix >> sh) << (sh + (kyb ? 2 : 1))) | (ix & (d - ADDR_W'(1)));
        if (kyb) return {base + (d << 1) + d, base + (d << 1), base + d, base};
        else     return {base + d, base + d, base, base};
    endfunction

    assign nxt_stage = inv_q ? stage_q - 3'd1 : stage_q + 3'd1;

    always_comb begin
        state_d = state_q;
        kyb_d   = kyb_q;
        inv_d   = inv_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                kyb_d   = KD_mode;
`ifdef ADDR_SEQ_INTT_EN
                inv_d   = inv;
`else
                inv_d   = 1'b0;
`endif
                stage_d = inv_d ? f_top(KD_mode) : 3'd0;
                idx_d   = '0;
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            RUN: if (out_ready) begin
                if (idx_q == f_last_idx(kyb_q)) begin
                    if (stage_q == (inv_q ? 3'd0 : f_top(kyb_q))) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (STAGE_GAP == 0) begin
                        stage_d = nxt_stage;
                        idx_d   = '0;
                    end else begin
                        state_d = GAP;
                        valid_d = 1'b0;
                        gap_d   = GAP_W'(STAGE_GAP - 1);
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            GAP: if (gap_q == '0) begin
                state_d = RUN;
                stage_d = nxt_stage;
                idx_d   = '0;
                valid_d = 1'b1;
            end else begin
                gap_d = gap_q - GAP_W'(1);
            end
            FIN: state_d = IDLE;
        endcase
        last_d = valid_d && (idx_d == f_last_idx(kyb_d));
        addr_d = valid_d ? f_addr(kyb_d, stage_d, idx_d) : addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kyb_q   <= 1'b0;
            inv_q   <= 1'b0;
            stage_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            kyb_q   <= kyb_d;
            inv_q   <= inv_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid  = valid_q;
    assign old_add_0  = addr_q[ADDR_W-1:0];
    assign old_add_1  = addr_q[2*ADDR_W-1:ADDR_W];
    assign old_add_2  = addr_q[3*ADDR_W-1:2*ADDR_W];
    assign old_add_3  = addr_q[4*ADDR_W-1:3*ADDR_W];
    assign stage      = stage_q;
    assign stage_last = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Randomized bench for ntt_addr_seq against a queue-based address-stream model.
module tb_ntt_addr_seq;

    localparam int KY_LOGN   = 7;
    localparam int DI_LOGN   = 8;
    localparam int ADDR_W    = 8;
    localparam int STAGE_GAP = 2;

    logic              clk = 1'b0;
    logic              rst, start, KD_mode, out_ready;
`ifdef ADDR_SEQ_INTT_EN
    logic              inv;
`endif
    logic              out_valid;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [2:0]        stage;
    logic              stage_last, busy, done;

    always #5 clk = ~clk;

    ntt_addr_seq #(
        .KY_LOGN(KY_LOGN), .DI_LOGN(DI_LOGN),
        .ADDR_W(ADDR_W), .STAGE_GAP(STAGE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .KD_mode(KD_mode),
`ifdef ADDR_SEQ_INTT_EN
        .inv(inv),
`endif
        .out_ready(out_ready), .out_valid(out_valid),
        .old_add_0(a0), .old_add_1(a1), .old_add_2(a2), .old_add_3(a3),
        .stage(stage), .stage_last(stage_last), .busy(busy), .done(done)
    );

    typedef struct {
        bit kyb;
        int stg;
        int idx;
        bit last;
        int e0, e1, e2, e3;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    chk_en = 1'b0;
    int    rdy_pct = 100;
    int    beats_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected beat stream straight from the stage/distance/base formulas.
    function automatic void build(input bit kyb, input bit iv);
        int kd[4] = '{1, 4, 16, 32};
        int nst = kyb ? 4 : DI_LOGN;
        int nb  = kyb ? (1 << (KY_LOGN - 2)) : (1 << (DI_LOGN - 1));
        int s, d, r, base;
        beat_t e;
        for (int k = 0; k < nst; k++) begin
            s = iv ? nst - 1 - k : k;
            d = kyb ? kd[s] : (1 << s);
            r = kyb ? 4 : 2;
            for (int i = 0; i < nb; i++) begin
                base  = (i / d) * r * d + (i % d);
                e.kyb = kyb;
                e.stg = s;
                e.idx = i;
                e.last = (i == nb - 1);
                if (kyb) begin
                    e.e0 = base; e.e1 = base + d;
                    e.e2 = base + 2 * d; e.e3 = base + 3 * d;
                end else begin
                    e.e0 = base; e.e1 = base;
                    e.e2 = base + d; e.e3 = base + d;
                end
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic lit(input string nm, input int x0, input int x1,
                       input int x2, input int x3);
        chk({nm, "_a0"}, int'(a0), x0);
        chk({nm, "_a1"}, int'(a1), x1);
        chk({nm, "_a2"}, int'(a2), x2);
        chk({nm, "_a3"}, int'(a3), x3);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (chk_en && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = exp_q[0];
                chk("stage", int'(stage), e.stg);
                chk("stage_last", int'(stage_last), int'(e.last));
                chk("addr0", int'(a0), e.e0);
                chk("addr1", int'(a1), e.e1);
                chk("addr2", int'(a2), e.e2);
                chk("addr3", int'(a3), e.e3);
                if (e.kyb && e.stg == 0 && e.idx == 0)   lit("k_s0_i0", 0, 1, 2, 3);
                if (e.kyb && e.stg == 1 && e.idx == 5)   lit("k_s1_i5", 17, 21, 25, 29);
                if (e.kyb && e.stg == 3 && e.idx == 31)  lit("k_s3_i31", 31, 63, 95, 127);
                if (e.kyb && e.stg == 3 && e.idx == 0)   lit("k_s3_i0", 0, 32, 64, 96);
                if (e.kyb && e.stg == 0 && e.idx == 31)  lit("k_s0_i31", 124, 125, 126, 127);
                if (!e.kyb && e.stg == 0 && e.idx == 0)  lit("d_s0_i0", 0, 0, 1, 1);
                if (!e.kyb && e.stg == 2 && e.idx == 5)  lit("d_s2_i5", 9, 9, 13, 13);
                if (!e.kyb && e.stg == 7 && e.idx == 127) lit("d_s7_i127", 127, 127, 255, 255);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats_seen++;
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    task automatic run(input bit kyb, input bit iv, input bit mis);
        int  n, nb, gaps;
        bit  to;
        nb   = kyb ? (1 << (KY_LOGN - 2)) : (1 << (DI_LOGN - 1));
        gaps = ((kyb ? 4 : DI_LOGN) - 1) * STAGE_GAP;
        exp_q.delete();
        build(kyb, iv);
        nb = exp_q.size();
        beats_seen = 0;
        @(posedge clk);
        #1 start = 1'b1;
        KD_mode = kyb;
`ifdef ADDR_SEQ_INTT_EN
        inv = iv;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        chk("first_valid", int'(out_valid), 1);
        chk("busy_after_start", int'(busy), 1);
        chk("first_stage", int'(stage), iv ? (kyb ? 3 : DI_LOGN - 1) : 0);
        n  = 0;
        to = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            #1 n++;
            if (done) begin
                to = 1'b0;
                break;
            end
            if (mis) begin
                start   = ($urandom_range(3) == 0);
                KD_mode = 1'($urandom_range(1));
            end
        end
        chk("done_timeout", int'(to), 0);
        chk("beats_left", exp_q.size(), 0);
        chk("beats_seen", beats_seen, nb);
        chk("busy_at_done", int'(busy), 0);
        chk("valid_at_done", int'(out_valid), 0);
        if (rdy_pct == 100) chk("cycles_to_done", n, nb + gaps);
        start   = 1'b1;
        KD_mode = ~kyb;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_single_pulse", int'(done), 0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("idle_valid", int'(out_valid), 0);
            chk("idle_busy", int'(busy), 0);
        end
    endtask

    task automatic zero_outputs(input string nm);
        chk({nm, "_valid"}, int'(out_valid), 0);
        chk({nm, "_addr"}, int'({a3, a2, a1, a0}), 0);
        chk({nm, "_stage"}, int'(stage), 0);
        chk({nm, "_last"}, int'(stage_last), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
    endtask

    initial begin
        bit to;
        rst     = 1'b1;
        start   = 1'b0;
        KD_mode = 1'b0;
`ifdef ADDR_SEQ_INTT_EN
        inv     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 zero_outputs("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        rdy_pct = 100;
        run(1'b1, 1'b0, 1'b0);
        run(1'b0, 1'b0, 1'b0);
        rdy_pct = 50;
        run(1'b1, 1'b0, 1'b1);
        run(1'b0, 1'b0, 1'b1);

        rdy_pct = 100;
        exp_q.delete();
        build(1'b1, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        KD_mode = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1 if (stage == 3'd2 && out_valid) begin
                to = 1'b0;
                break;
            end
        end
        chk("reach_stage2", int'(to), 0);
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        #2 rst = 1'b1;
        #1 zero_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
        run(1'b0, 1'b0, 1'b0);

`ifdef ADDR_SEQ_INTT_EN
        run(1'b1, 1'b1, 1'b0);
        rdy_pct = 50;
        run(1'b0, 1'b1, 1'b1);
        rdy_pct = 100;
        run(1'b1, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
